// File: rtl/mcm_pkg.sv
// Shared constants and types for the MCM_5 tap sequencer.
package mcm_pkg;

  // MCM_5 output index map
  localparam logic [2:0] IDX_16 = 3'd0;
  localparam logic [2:0] IDX_51 = 3'd1;
  localparam logic [2:0] IDX_19 = 3'd2;
  localparam logic [2:0] IDX_27 = 3'd3;
  localparam logic [2:0] IDX_M2 = 3'd4;
  localparam logic [2:0] IDX_M3 = 3'd5;
  localparam logic [2:0] IDX_3  = 3'd6;
  localparam logic [2:0] IDX_11 = 3'd7;

  localparam int PROD_W    = 16;
  localparam int ACC_W     = 18;
  localparam int ROUND_OFS = 32;
  localparam int SHIFT     = 6;

  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  // Sign-extend a product to accumulator width
  function automatic acc_t sext_prod(input prod_t p);
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/mcm_tap_sequencer_if.sv
// Config, sample-in and prediction-out handshakes of the tap sequencer.
interface mcm_tap_sequencer_if #(
  parameter int BIT_DEPTH = 8,
  parameter int LEN_W     = 6
);
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [11:0]          cfg_tap_sel;
  logic [LEN_W-1:0]     cfg_len;
  logic                 in_valid;
  logic                 in_ready;
  logic [BIT_DEPTH-1:0] in_sample;
  logic                 out_valid;
  logic                 out_ready;
  logic [BIT_DEPTH-1:0] out_sample;
  logic                 out_last;
  logic                 busy;

  modport slave (
    input  cfg_valid, cfg_tap_sel, cfg_len, in_valid, in_sample, out_ready,
    output cfg_ready, in_ready, out_valid, out_sample, out_last, busy
  );

  modport master (
    output cfg_valid, cfg_tap_sel, cfg_len, in_valid, in_sample, out_ready,
    input  cfg_ready, in_ready, out_valid, out_sample, out_last, busy
  );
endinterface

// File: rtl/mcm_tap_sequencer_mcm5.sv
// Multiplierless MCM_5 block: all eight constant products of one sample.
module mcm_tap_sequencer_mcm5
  import mcm_pkg::*;
#(
  parameter int BIT_DEPTH = 8
) (
  input  logic [BIT_DEPTH-1:0] i_x,
  output prod_t                o_prod [8]
);

  prod_t w_x;

  // Sample is unsigned, so zero-extend before the shift-add network
  assign w_x = prod_t'({{(PROD_W-BIT_DEPTH){1'b0}}, i_x});

  assign o_prod[IDX_16] = w_x <<< 4;
  assign o_prod[IDX_51] = (w_x <<< 5) + (w_x <<< 4) + (w_x <<< 1) + w_x;
  assign o_prod[IDX_19] = (w_x <<< 4) + (w_x <<< 1) + w_x;
  assign o_prod[IDX_27] = (w_x <<< 5) - (w_x <<< 2) - w_x;
  assign o_prod[IDX_M2] = -(w_x <<< 1);
  assign o_prod[IDX_M3] = -((w_x <<< 1) + w_x);
  assign o_prod[IDX_3]  = (w_x <<< 1) + w_x;
  assign o_prod[IDX_11] = (w_x <<< 3) + (w_x <<< 1) + w_x;

endmodule

// File: rtl/mcm_tap_sequencer.sv
// 4-tap transposed-form angular interpolator sharing one MCM_5 instance.
module mcm_tap_sequencer
  import mcm_pkg::*;
#(
  parameter int BIT_DEPTH = 8,
  parameter int MAX_LEN   = 64,
  parameter int LEN_W     = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  mcm_tap_sequencer_if.slave bus
);

  localparam int CNT_W   = $clog2(MAX_LEN + 1);
  localparam int PIX_MAX = (1 << BIT_DEPTH) - 1;

  state_t               r_state, w_state_next;
  logic [3:0][2:0]      r_sel;
  logic [CNT_W-1:0]     r_len, r_out_cnt;
  logic [1:0]           r_in_cnt;
  acc_t                 r_t1, r_t2, r_t3;
  logic                 r_out_valid, r_out_last;
  logic [BIT_DEPTH-1:0] r_out_sample;

  prod_t                w_prod [8];
  acc_t                 w_tap [4];
  acc_t                 w_acc, w_scaled;
  logic [BIT_DEPTH-1:0] w_clip;
  logic                 w_cfg_ready, w_in_ready, w_accept, w_cfg_take;
  logic                 w_out_fire, w_last_in;

  mcm_tap_sequencer_mcm5 #(.BIT_DEPTH(BIT_DEPTH)) u_mcm (
    .i_x    (bus.in_sample),
    .o_prod (w_prod)
  );

  // Per-tap 8:1 product select, sign-extended to accumulator width
  for (genvar gi = 0; gi < 4; gi++) begin : g_tap
    assign w_tap[gi] = sext_prod(w_prod[r_sel[gi]]);
  end

  assign w_acc      = r_t3 + w_tap[3];
  assign w_scaled   = (w_acc + acc_t'(ROUND_OFS)) >>> SHIFT;
  assign w_last_in  = (r_out_cnt == r_len - CNT_W'(1));
  assign w_out_fire = r_out_valid & bus.out_ready;
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_cfg_take = w_cfg_ready & bus.cfg_valid;

  // Saturate the rounded result into the unsigned sample range
  always_comb begin
    w_clip = w_scaled[BIT_DEPTH-1:0];
    if (w_scaled[ACC_W-1])
      w_clip = '0;
    else if (w_scaled > acc_t'(PIX_MAX))
      w_clip = '1;
  end

  // Next-state and handshake readiness
  always_comb begin
    w_state_next = r_state;
    w_cfg_ready  = 1'b0;
    w_in_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        w_cfg_ready = 1'b1;
        if (bus.cfg_valid) w_state_next = FILL;
      end
      FILL: begin
        w_in_ready = 1'b1;
        if (bus.in_valid && r_in_cnt == 2'd2) w_state_next = RUN;
      end
      RUN: begin
        // A pending output must leave before a new one can be registered
        w_in_ready = !r_out_valid || bus.out_ready;
        if (bus.in_valid && w_in_ready && w_last_in) w_state_next = DRAIN;
      end
      DRAIN: begin
        if (w_out_fire) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Latch block configuration; a zero length means a full-size block
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel <= '0;
      r_len <= '0;
    end else if (w_cfg_take) begin
      r_sel <= bus.cfg_tap_sel;
      r_len <= (bus.cfg_len == LEN_W'(0)) ? CNT_W'(MAX_LEN) : CNT_W'(bus.cfg_len);
    end
  end

  // Transposed delay line, advanced only by accepted samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t1 <= '0;
      r_t2 <= '0;
      r_t3 <= '0;
    end else if (w_cfg_take) begin
      r_t1 <= '0;
      r_t2 <= '0;
      r_t3 <= '0;
    end else if (w_accept) begin
      r_t1 <= w_tap[0];
      r_t2 <= r_t1 + w_tap[1];
      r_t3 <= r_t2 + w_tap[2];
    end
  end

  // Fill and output counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else if (w_cfg_take) begin
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else if (w_accept) begin
      if (r_state == FILL) r_in_cnt  <= r_in_cnt + 2'd1;
      if (r_state == RUN)  r_out_cnt <= r_out_cnt + CNT_W'(1);
    end
  end

  // Output register: load on a RUN acceptance, otherwise empty on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_sample <= '0;
      r_out_last   <= 1'b0;
    end else if (r_state == RUN && w_accept) begin
      r_out_valid  <= 1'b1;
      r_out_sample <= w_clip;
      r_out_last   <= w_last_in;
    end else if (w_out_fire) begin
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
    end
  end

  assign bus.cfg_ready  = w_cfg_ready;
  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_sample = r_out_sample;
  assign bus.out_last   = r_out_last;
  assign bus.busy       = (r_state != IDLE) || r_out_valid;

endmodule

// File: tb/tb_mcm_tap_sequencer.sv
// Directed bench for mcm_tap_sequencer with hand-computed expectations.
module tb_mcm_tap_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mcm_tap_sequencer_if #(.BIT_DEPTH(8), .LEN_W(6)) bus ();

  mcm_tap_sequencer #(.BIT_DEPTH(8), .MAX_LEN(64), .LEN_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int got_q[$];
  int last_q[$];
  int cyc_q[$];

  // Free-running cycle count for throughput measurement
  always @(posedge clk) cyc <= cyc + 1;

  // Record every output handshake
  always @(posedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      got_q.push_back(int'(bus.out_sample));
      last_q.push_back(int'(bus.out_last));
      cyc_q.push_back(cyc);
      $display("OUT idx=%0d sample=%0d last=%0d", got_q.size() - 1, bus.out_sample, bus.out_last);
    end
  end

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, act, exp);
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    last_q.delete();
    cyc_q.delete();
  endtask

  task automatic send_cfg(input logic [11:0] sel, input int len);
    int n = 0;
    bus.cfg_tap_sel = sel;
    bus.cfg_len     = 6'(len);
    bus.cfg_valid   = 1'b1;
    while (!bus.cfg_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cfg_accept", int'(bus.cfg_ready), 1);
    @(negedge clk);
    bus.cfg_valid = 1'b0;
  endtask

  task automatic send_one(input int x);
    int n = 0;
    bus.in_sample = 8'(x);
    bus.in_valid  = 1'b1;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", int'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_samples(input int xs[$]);
    foreach (xs[i]) send_one(xs[i]);
  endtask

  task automatic wait_outs(input int n);
    int k = 0;
    while (got_q.size() < n && k < 300) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic check_outs(input string tag, input int exp[$]);
    chk({tag, "_count"}, got_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s_s%0d", tag, i), got_q[i], exp[i]);
      chk($sformatf("%s_l%0d", tag, i), last_q[i], (i == exp.size() - 1) ? 1 : 0);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_cfg_ready"}, int'(bus.cfg_ready), 1);
    chk({tag, "_busy"}, int'(bus.busy), 0);
  endtask

  // Safety net against a hung handshake
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int q[$];
    int e[$];

    bus.cfg_valid   = 1'b0;
    bus.cfg_tap_sel = '0;
    bus.cfg_len     = '0;
    bus.in_valid    = 1'b0;
    bus.in_sample   = '0;
    bus.out_ready   = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_cfg_ready", int'(bus.cfg_ready), 1);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_sample", int'(bus.out_sample), 0);
    chk("rst_out_last", int'(bus.out_last), 0);
    chk("rst_busy", int'(bus.busy), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Flat response: -3+51+19-3 = 64, so 100 in gives 100 out; DRAIN held
    clear_mon();
    send_cfg({3'd5, 3'd2, 3'd1, 3'd5}, 4);
    q = {};
    for (int i = 0; i < 7; i++) q.push_back(100);
    send_samples(q);
    bus.out_ready = 1'b0;
    chk("drain_out_valid", int'(bus.out_valid), 1);
    chk("drain_out_last", int'(bus.out_last), 1);
    chk("drain_out_sample", int'(bus.out_sample), 100);
    chk("drain_cfg_ready", int'(bus.cfg_ready), 0);
    chk("drain_busy", int'(bus.busy), 1);
    chk("drain_in_ready", int'(bus.in_ready), 0);
    repeat (2) @(negedge clk);
    chk("drain_hold_valid", int'(bus.out_valid), 1);
    chk("drain_hold_count", got_q.size(), 3);
    bus.out_ready = 1'b1;
    wait_outs(4);
    e = {100, 100, 100, 100};
    check_outs("flat", e);
    check_idle("flat_end");

    // Step response with 16x taps: 16*64=1024 -> 16, 2048 -> 32
    clear_mon();
    send_cfg(12'h000, 2);
    q = {0, 0, 0, 64, 64};
    send_samples(q);
    wait_outs(2);
    e = {16, 32};
    check_outs("step", e);
    check_idle("step_end");

    // Clip high: 4*51*255 = 52020 -> 813 -> 255
    clear_mon();
    send_cfg(12'h249, 1);
    q = {255, 255, 255, 255};
    send_samples(q);
    wait_outs(1);
    e = {255};
    check_outs("cliphi", e);

    // Clip low: 4*-3*255 = -3060 -> -48 -> 0
    clear_mon();
    send_cfg(12'hB6D, 1);
    send_samples(q);
    wait_outs(1);
    e = {0};
    check_outs("cliplo", e);

    // Tap order: 16*10 + 3*20 - 2*30 + 11*40 = 600 -> 9
    clear_mon();
    send_cfg({3'd7, 3'd4, 3'd6, 3'd0}, 1);
    q = {10, 20, 30, 40};
    send_samples(q);
    wait_outs(1);
    e = {9};
    check_outs("order", e);

    // Remaining constants: 27*8 + 19*4 + 16*2 + 51*1 = 375 -> 6
    clear_mon();
    send_cfg({3'd1, 3'd0, 3'd2, 3'd3}, 1);
    q = {8, 4, 2, 1};
    send_samples(q);
    wait_outs(1);
    e = {6};
    check_outs("consts", e);

    // Backpressure: 16x taps on 4,8,..,44 -> outputs 4j+10; output 2 (18) is held
    clear_mon();
    send_cfg(12'h000, 8);
    q = {};
    for (int i = 0; i < 11; i++) q.push_back(4 * (i + 1));
    fork
      send_samples(q);
      begin
        repeat (6) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
      begin
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("bp_valid", int'(bus.out_valid), 1);
        chk("bp_sample", int'(bus.out_sample), 18);
        chk("bp_in_ready", int'(bus.in_ready), 0);
        repeat (3) @(negedge clk);
        chk("bp_hold_sample", int'(bus.out_sample), 18);
        chk("bp_hold_in_ready", int'(bus.in_ready), 0);
        chk("bp_hold_count", got_q.size(), 2);
      end
    join
    wait_outs(8);
    e = {};
    for (int j = 0; j < 8; j++) e.push_back(4 * j + 10);
    check_outs("bp", e);
    check_idle("bp_end");

    // Reset mid-block after the 5th input
    clear_mon();
    send_cfg(12'h000, 8);
    q = {4, 8, 12, 16, 20};
    send_samples(q);
    chk("prerst_valid", int'(bus.out_valid), 1);
    chk("prerst_sample", int'(bus.out_sample), 14);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", int'(bus.out_valid), 0);
    chk("midrst_sample", int'(bus.out_sample), 0);
    chk("midrst_last", int'(bus.out_last), 0);
    chk("midrst_in_ready", int'(bus.in_ready), 0);
    check_idle("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_mon();
    send_cfg({3'd5, 3'd2, 3'd1, 3'd5}, 2);
    q = {10, 10, 10, 10, 10};
    send_samples(q);
    wait_outs(2);
    e = {10, 10};
    check_outs("postrst", e);

    // Full-size block via cfg_len=0, with a stray config offered mid-run
    clear_mon();
    send_cfg({3'd5, 3'd2, 3'd1, 3'd5}, 0);
    for (int i = 0; i < 67; i++) begin
      if (i == 30) begin
        bus.cfg_len   = 6'd5;
        bus.cfg_valid = 1'b1;
      end
      if (i == 40) begin
        chk("run_cfg_ready", int'(bus.cfg_ready), 0);
        chk("run_busy", int'(bus.busy), 1);
        bus.cfg_valid = 1'b0;
      end
      send_one(100);
    end
    wait_outs(64);
    e = {};
    for (int j = 0; j < 64; j++) e.push_back(100);
    check_outs("max", e);
    if (cyc_q.size() >= 64) chk("max_throughput", cyc_q[63] - cyc_q[0], 63);
    repeat (3) @(negedge clk);
    chk("max_no_extra", got_q.size(), 64);
    check_idle("max_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcm_tap_sequencer.md
Name: mcm_tap_sequencer

Overview:
Sequences a stream of 8-bit reference samples through one MCM_5 constant-multiplier instance to produce 4-tap intra angular interpolated prediction samples. It uses a transposed-form filter, so a single MCM evaluation per accepted sample is enough. Per-block configuration selects which of the 8 MCM products feeds each tap. The block sits between the reference-sample fetch stream and the prediction-sample writeback, with valid/ready handshakes on every interface.

Parameters:
BIT_DEPTH, 8, sample width on in_sample/out_sample
MAX_LEN, 64, maximum output samples per block
LEN_W, 6, width of cfg_len (cfg_len=0 encodes MAX_LEN)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  block configuration offered
cfg_ready  out  1  sequencer idle and accepting config
cfg_tap_sel  in  12  {sel3,sel2,sel1,sel0}, 3-bit MCM output index per tap
cfg_len  in  LEN_W  outputs in block (0 = MAX_LEN)
in_valid  in  1  reference sample offered
in_ready  out  1  sample accepted this cycle when in_valid&in_ready
in_sample  in  BIT_DEPTH  unsigned reference sample
out_valid  out  1  prediction sample valid
out_ready  in  1  downstream accepts
out_sample  out  BIT_DEPTH  clipped prediction sample
out_last  out  1  final sample of block, qualified by out_valid
busy  out  1  state != IDLE or out_valid

Behaviour:
- Reset (async, rst_n low): state=IDLE; cfg_ready=1; in_ready=0; out_valid=0; out_sample=0; out_last=0; busy=0; r1/r2/r3=0; counters=0.
- MCM output index map: 0=16x, 1=51x, 2=19x, 3=27x, 4=-2x, 5=-3x, 6=3x, 7=11x. P[i] is the signed 16-bit product for the current in_sample.
- Filter: y_k = c0*x_{k-3} + c1*x_{k-2} + c2*x_{k-1} + c3*x_k, with c_j = coefficient selected by sel_j.
- Transposed pipeline, updated only on an accepted sample:
  - r1 <= P[sel0]
  - r2 <= r1 + P[sel1]
  - r3 <= r2 + P[sel2]
  - acc = r3 + P[sel3]
- Accumulators are 18-bit signed; all products are sign-extended.
- out_sample <= clip((acc + 32) >>> 6) to the range [0, 2^BIT_DEPTH - 1].
- FSM states:
  - IDLE: cfg_ready=1. On cfg_valid, latch sel/len, clear r1..r3, clear in_cnt and out_cnt, go to FILL.
  - FILL: in_ready=1. Accept 3 samples, no output. After the 3rd acceptance, go to RUN.
  - RUN: in_ready = !out_valid | out_ready. Each accepted sample registers one output next cycle (latency 1 cycle from the 4th, 5th, ... acceptance).
    - out_cnt increments on acceptance; out_last=1 when out_cnt reaches len-1.
    - After the last input is accepted, in_ready=0; go to DRAIN.
  - DRAIN: hold out_valid until out_ready; then go to IDLE.
- Total inputs per block = len+3; total outputs = len.
- Backpressure: out_valid&!out_ready holds out_sample, out_last and r1..r3 stable; in_ready=0 in that cycle.
- Simultaneous out handshake and new input in RUN: the output is consumed and the new one registered in the same cycle, giving 1 sample/cycle throughput.
- cfg_valid while not IDLE is ignored (cfg_ready=0). A config arriving in the same cycle DRAIN empties is not accepted until the next cycle.
- The last output of a block is never dropped: IDLE is entered only after out_last is handshaken.
- cfg_len=0 produces MAX_LEN outputs.
- rst_n asserted mid-block aborts the block immediately. The partial output is discarded and the next block needs a fresh cfg.

Decomposition:
- Shared package mcm_pkg holds:
  - MCM index constants (IDX_16, IDX_51, IDX_19, IDX_27, IDX_M2, IDX_M3, IDX_3, IDX_11)
  - PROD_W=16 and ACC_W=18
  - ROUND_OFS=32 and SHIFT=6
  - state typedef {IDLE, FILL, RUN, DRAIN}
- Sub-module: one MCM_5 instance (combinational) driven by in_sample. A 4-way 8:1 product mux, the FSM and the accumulators live in mcm_tap_sequencer.

Test Plan:
- cfg sel=(5,1,2,5) [-3,51,19,-3], len=4, inputs 100 x7 -> outputs 100,100,100,100; out_last on the 4th; then cfg_ready=1.
- cfg sel=(0,0,0,0) [16 each], len=2, inputs 0,0,0,64,64 -> outputs (1024+32)>>6=16, then 32.
- cfg sel=(1,1,1,1), inputs 255 x4, len=1 -> acc=52020, out=255 (clip high); sel=(5,5,5,5), 255 x4 -> acc=-3060, out=0 (clip low).
- Backpressure: len=8 streamed, out_ready low for 5 cycles mid-block -> out_sample and in_ready=0 held; no lost or duplicated samples; 8 outputs in order; throughput 1/cycle when out_ready=1.
- rst_n pulsed low after the 5th input of a len=8 block -> outputs cleared immediately; a new cfg len=2 with inputs 10 x5 using sel=(5,1,2,5) -> 10,10.
- cfg_len=0 -> exactly 64 outputs from 67 inputs; cfg_valid during RUN is ignored and cfg_ready stays 0 until the final handshake.
